// File: rtl/cdb_arbiter_if.sv
// Result-bus arbitration bundle between FU issue registers and the CDB stage.
// Requesters drive req/squash; the arbiter returns same-cycle and registered grants.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 6,
  parameter int N       = 2
);
  logic [NUM_REQ-1:0]         req;
  logic                       squash;
  logic [NUM_REQ-1:0]         gnt;
  logic [N-1:0][NUM_REQ-1:0]  gnt_bus;
  logic [NUM_REQ-1:0]         urgent;

  modport master (output req, squash, input gnt, gnt_bus, urgent);
  modport slave  (input req, squash, output gnt, gnt_bus, urgent);
endinterface

// File: rtl/cdb_arbiter.sv
// Starvation-aware N-slot CDB arbiter: urgent class round-robin, then fixed priority.
// gnt is zero-latency; gnt_bus/urgent are registered. Unserved requests are simply held (level req).
module cdb_arbiter #(
  parameter int NUM_REQ      = 6,
  parameter int N            = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clock,
  input  logic            reset,
  cdb_arbiter_if.slave    bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = $clog2(N + 1);

  logic [WW-1:0]              wait_q [NUM_REQ];
  logic [IW-1:0]              rr_ptr;
  logic [N-1:0][NUM_REQ-1:0]  gnt_bus_q;

  logic [NUM_REQ-1:0]         urg;
  logic [NUM_REQ-1:0]         gnt_c;
  logic [N-1:0][NUM_REQ-1:0]  slot_c;
  logic                       any_urg;
  logic [IW-1:0]              last_urg;
  logic [CW-1:0]              cnt;
  logic [IW:0]                sum;
  logic [IW-1:0]              idx;

  always_comb begin
    urg = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      urg[k] = (wait_q[k] == WW'(STARVE_LIMIT));
    end
  end

  // Slots fill in selection order: urgent (circular from rr_ptr) first, then ascending index.
  always_comb begin
    gnt_c    = '0;
    slot_c   = '0;
    cnt      = '0;
    any_urg  = 1'b0;
    last_urg = '0;
    sum      = '0;
    idx      = '0;
    if (!reset && !bus.squash) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        sum = {1'b0, rr_ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(NUM_REQ)) begin
          sum = sum - (IW+1)'(NUM_REQ);
        end
        idx = sum[IW-1:0];
        if (bus.req[idx] && urg[idx] && (cnt < CW'(N))) begin
          gnt_c[idx] = 1'b1;
          for (int s = 0; s < N; s++) begin
            if (cnt == CW'(s)) begin
              slot_c[s][idx] = 1'b1;
            end
          end
          cnt      = cnt + CW'(1);
          any_urg  = 1'b1;
          last_urg = idx;
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = IW'(k);
        if (bus.req[idx] && !urg[idx] && (cnt < CW'(N))) begin
          gnt_c[idx] = 1'b1;
          for (int s = 0; s < N; s++) begin
            if (cnt == CW'(s)) begin
              slot_c[s][idx] = 1'b1;
            end
          end
          cnt = cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.squash) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        wait_q[k] <= '0;
      end
      rr_ptr    <= '0;
      gnt_bus_q <= '0;
    end else begin
      // Any grant or a dropped request forfeits accumulated waiting credit.
      for (int k = 0; k < NUM_REQ; k++) begin
        if (bus.req[k] && !gnt_c[k]) begin
          if (!urg[k]) begin
            wait_q[k] <= wait_q[k] + WW'(1);
          end
        end else begin
          wait_q[k] <= '0;
        end
      end
      if (any_urg) begin
        rr_ptr <= (last_urg == IW'(NUM_REQ - 1)) ? '0 : last_urg + IW'(1);
      end
      gnt_bus_q <= slot_c;
    end
  end

  assign bus.gnt     = gnt_c;
  assign bus.gnt_bus = gnt_bus_q;
  assign bus.urgent  = urg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed checks of cdb_arbiter with NUM_REQ=6, N=2, STARVE_LIMIT=3.
module tb_cdb_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errs   = 0;
  int   checks = 0;

  cdb_arbiter_if #(.NUM_REQ(6), .N(2)) bus_if ();

  cdb_arbiter #(.NUM_REQ(6), .N(2), .STARVE_LIMIT(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
  task automatic set_in(input logic [5:0] r, input logic s);
    bus_if.req    = r;
    bus_if.squash = s;
    #2;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(6'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scenario 4 expected values per cycle after reset with req=6'b111011 held.
  logic [5:0] rot_gnt [6] = '{6'b000011, 6'b000011, 6'b000011, 6'b011000, 6'b100001, 6'b000011};
  logic [5:0] rot_urg [6] = '{6'b000000, 6'b000000, 6'b000000, 6'b111000, 6'b100000, 6'b000000};

  initial begin
    bus_if.req    = '0;
    bus_if.squash = 1'b0;
    tick();

    // 1: reset holds grants low even with all requests up
    reset = 1'b1;
    set_in(6'b111111, 1'b0);
    chk("rst_gnt0", bus_if.gnt, 6'b0);
    tick();
    set_in(6'b111111, 1'b0);
    chk("rst_gnt1", bus_if.gnt, 6'b0);
    chk("rst_bus0", bus_if.gnt_bus[0], 6'b0);
    chk("rst_bus1", bus_if.gnt_bus[1], 6'b0);
    chk("rst_urg", bus_if.urgent, 6'b0);
    tick();
    reset = 1'b0;
    set_in(6'b111111, 1'b0);
    chk("rst_first_gnt", bus_if.gnt, 6'b000011);
    tick();

    // 2: starvation promotion of requester 2
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(6'b000111, 1'b0);
      chk("starve_gnt", bus_if.gnt, 6'b000011);
      chk("starve_urg", bus_if.urgent, 6'b0);
      tick();
    end
    set_in(6'b000111, 1'b0);
    chk("promo_urg", bus_if.urgent, 6'b000100);
    chk("promo_gnt", bus_if.gnt, 6'b000101);
    tick();
    set_in(6'b000111, 1'b0);
    chk("promo_bus0", bus_if.gnt_bus[0], 6'b000100);
    chk("promo_bus1", bus_if.gnt_bus[1], 6'b000001);
    chk("post_urg", bus_if.urgent, 6'b0);
    chk("post_gnt", bus_if.gnt, 6'b000011);
    tick();

    // 3: slot latency and ordering
    do_reset();
    set_in(6'b110000, 1'b0);
    chk("lat_gnt", bus_if.gnt, 6'b110000);
    tick();
    set_in(6'b000000, 1'b0);
    chk("lat_gnt_idle", bus_if.gnt, 6'b0);
    chk("lat_bus0", bus_if.gnt_bus[0], 6'b010000);
    chk("lat_bus1", bus_if.gnt_bus[1], 6'b100000);
    tick();
    set_in(6'b000000, 1'b0);
    chk("idle_bus0", bus_if.gnt_bus[0], 6'b0);
    chk("idle_bus1", bus_if.gnt_bus[1], 6'b0);
    tick();

    // 4: urgent rotation with three simultaneous urgent requesters
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_in(6'b111011, 1'b0);
      chk("rot_gnt", bus_if.gnt, rot_gnt[c]);
      chk("rot_urg", bus_if.urgent, rot_urg[c]);
      chk("rot_pop", 32'($countones(bus_if.gnt) <= 2), 32'd1);
      if (c == 4) begin
        chk("rot_bus0", bus_if.gnt_bus[0], 6'b001000);
        chk("rot_bus1", bus_if.gnt_bus[1], 6'b010000);
      end
      if (c == 5) begin
        chk("rot_bus0b", bus_if.gnt_bus[0], 6'b100000);
        chk("rot_bus1b", bus_if.gnt_bus[1], 6'b000001);
      end
      tick();
    end

    // 5: squash mid-wait restarts the starvation count
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_in(6'b000111, c == 2);
      if (c == 2) chk("sq_gnt", bus_if.gnt, 6'b0);
      else if (c == 6) chk("sq_promo_gnt", bus_if.gnt, 6'b000101);
      else chk("sq_gnt_norm", bus_if.gnt, 6'b000011);
      if (c == 3) begin
        chk("sq_bus0", bus_if.gnt_bus[0], 6'b0);
        chk("sq_bus1", bus_if.gnt_bus[1], 6'b0);
      end
      chk("sq_urg", bus_if.urgent, (c == 6) ? 6'b000100 : 6'b0);
      tick();
    end

    // 6: withdrawing a request discards its waiting credit
    do_reset();
    for (int c = 0; c < 7; c++) begin
      set_in((c == 2) ? 6'b000011 : 6'b000111, 1'b0);
      chk("wd_urg", bus_if.urgent, (c == 6) ? 6'b000100 : 6'b0);
      chk("wd_gnt", bus_if.gnt, (c == 6) ? 6'b000101 : 6'b000011);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Starvation-aware arbiter that shares the `N` Common Data Bus slots among the `NUM_REQ` functional-unit result requesters, ordered branch, ALU, mult, mem. It sits between the FU issue registers and the CDB register stage. Each cycle it issues same-cycle grants so FUs know whether they may advance, plus a registered per-slot one-hot grant bus that drives the CDB mux on the following cycle. Fixed priority is the default; a requester denied `STARVE_LIMIT` consecutive cycles is promoted to an urgent class, which is served round-robin ahead of normal traffic.

## Interface
- `NUM_REQ`, default 6: number of FU requesters; index 0 has the highest fixed priority.
- `N`, default 2: number of CDB slots, i.e. the maximum grants per cycle.
- `STARVE_LIMIT`, default 3: consecutive denials before a requester is promoted to urgent; must be ≥1.
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req`, in, `NUM_REQ`: per-FU request, level-sensitive, held until granted.
- `squash`, in, 1: mispredict flush; clears arbitration state and suppresses grants this cycle.
- `gnt`, out, `NUM_REQ`: combinational grants for this cycle; popcount ≤ `N`; `gnt` ⊆ `req`.
- `gnt_bus`, out, `N`×`NUM_REQ`: registered; slot *i* one-hot (or zero) of the requester granted slot *i* last cycle.
- `urgent`, out, `NUM_REQ`: registered; requesters currently in the urgent class.

## Operation
- **Per-requester wait counter** `wait[k]`
  - Width is `$clog2(STARVE_LIMIT+1)`.
  - Increments when `req[k] && !gnt[k]`.
  - Saturates at `STARVE_LIMIT`.
  - Clears when `gnt[k]` is asserted or `req[k]` is low.
- `urgent[k] = (wait[k] == STARVE_LIMIT)`, derived from the registered counter.
- **Round-robin pointer** `rr_ptr`
  - Width is `$clog2(NUM_REQ)`; reset value 0.
- **Grant selection, in order, until `N` slots are filled:**
  1. Urgent requesters, scanned circularly starting at `rr_ptr`.
  2. Non-urgent requesters, scanned by ascending index.
- **Slot assignment:** slot 0 receives the first selected requester, slot 1 the second, and so on. Unfilled slots are zero.
- **Pointer update:** if any urgent requester was granted, `rr_ptr` moves to (index of the last urgent grant + 1) mod `NUM_REQ`. Otherwise it holds.
- **Squash:** `gnt` = 0 this cycle. On the next edge, all `wait` counters clear, `rr_ptr` clears, and `gnt_bus` is loaded with 0.
- **No requests:** `req` = 0 gives `gnt` = 0; `gnt_bus` becomes 0 next cycle.
- **Invariants**
  - At most `N` bits set in `gnt`.
  - Each requester appears in at most one slot.
  - No slot carries more than one bit.

## Timing
- `gnt` is combinational from `req`, `squash` and registered state, with zero-cycle latency. A FU that sees `gnt[k]` in cycle t writes its result register at the end of cycle t.
- `gnt_bus` reflects the grants of cycle t during cycle t+1, aligned with the CDB register stage.
- **Promotion timing:** a requester denied in cycles t … t+`STARVE_LIMIT`-1 is urgent in cycle t+`STARVE_LIMIT` and is guaranteed a grant that cycle, provided at most `N` requesters are urgent.
- **Reset** (synchronous; takes priority over `squash`): `gnt_bus` = 0, `urgent` = 0, `wait` = 0, `rr_ptr` = 0. `gnt` is forced to 0 while `reset` is high.
- **`req[k]` dropping mid-wait:** `wait[k]` clears on the next edge, so there is no carried credit.
- **Simultaneous `squash` and urgent grants:** the squash wins; the pointer does not advance.
- **More than `N` urgent requesters:** the rotating `rr_ptr` bounds the wait to ⌈urgent count / `N`⌉ cycles after promotion. Counters stay saturated while waiting.

## Test plan
Parameters for all scenarios: `NUM_REQ`=6, `N`=2, `STARVE_LIMIT`=3.

1. **Reset:** hold `reset` with `req`=6'b111111 for 2 cycles → `gnt`=0, `gnt_bus`=0, `urgent`=0. Release reset → first `gnt`=6'b000011.
2. **Starvation promotion:** `req`=6'b000111 held from cycle 0.
   - Cycles 0–2: `gnt`=6'b000011.
   - Cycle 3: `urgent[2]`=1, `gnt`=6'b000101, `gnt_bus` slot0=6'b000100 and slot1=6'b000001 in cycle 4.
   - Cycle 4: `urgent`=0, `gnt`=6'b000011.
3. **Slot latency:** cycle 0 `req`=6'b110000, then 0 → cycle 0 `gnt`=6'b110000. Cycle 1 `gnt_bus` slot0=6'b010000, slot1=6'b100000. Cycle 2 `gnt_bus`=0.
4. **Urgent rotation:** preload `wait` so `urgent`=6'b111000 with `rr_ptr`=0 (hold `req`=6'b111011 from reset).
   - Urgent grants go 3,4, then 5 plus the next circular urgent.
   - Verify no urgent requester waits more than 2 cycles after promotion and `popcount(gnt)`≤2 every cycle.
5. **Squash mid-wait:** scenario 2 with `squash` in cycle 2 → cycle 2 `gnt`=0. Cycle 3 `gnt_bus`=0, `wait`=0, `urgent[2]`=0. Promotion of requester 2 is delayed to cycle 6.
6. **Request withdrawal:** requester 2 is denied 2 cycles, drops `req` for 1 cycle, then reasserts → not urgent until 3 further consecutive denials.
